// File: rtl/periph_arb_pkg.sv
// Shared definitions for the peripheral port arbiter: LSU-ID width,
// request-kind enum and the round-robin pointer helper.
package periph_arb_pkg;

  localparam int NUM_LSU_DEFAULT = 4;
  localparam int LSU_ID_WIDTH    = $clog2(NUM_LSU_DEFAULT);

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } reqKind_t;

  // Round-robin successor: the port after the winner, wrapping to 0.
  function automatic int rrNext(input int winner, input int numLsu);
    return (winner + 1 >= numLsu) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/periph_arb_id_fifo.sv
// Synchronous FIFO of LSU IDs for outstanding reads. The head entry is
// available combinationally so read data can be routed in the return cycle.
module periph_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PtrWidth = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PtrWidth-1:0] rdPtr;
  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth:0]   count;
  logic                doPush;
  logic                doPop;

  assign full   = (count == (PtrWidth+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  // Entry storage needs no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
      if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
      unique case ({doPush, doPop})
        2'b10:   count <= count + (PtrWidth+1)'(1);
        2'b01:   count <= count - (PtrWidth+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/periph_port_arbiter.sv
// Shares one single-ported peripheral between NUM_LSU load/store units.
// Round-robin selection, registered one-cycle issue, in-order read return.
// Optional macro PERIPH_ARB_FIXED_PRIORITY_EN: lowest-index candidate wins
// and the round-robin pointer is removed.
module periph_port_arbiter
  import periph_arb_pkg::*;
#(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int NUM_LSU              = NUM_LSU_DEFAULT,
  parameter int READ_FIFO_DEPTH      = 4
) (
  input  logic                                  iClk,
  input  logic                                  iReset,
  input  logic [NUM_LSU-1:0]                    iReadRequest,
  input  logic [NUM_LSU-1:0]                    iWriteRequest,
  input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0] iReadAddress,
  input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [NUM_LSU*INTERFACE_WIDTH-1:0]    iWriteData,
  input  logic [NUM_LSU*(INTERFACE_WIDTH/8)-1:0] iWriteEnable,
  output logic [NUM_LSU-1:0]                    oReadGrantNextCycle,
  output logic [NUM_LSU-1:0]                    oWriteGrantNextCycle,
  output logic [NUM_LSU*INTERFACE_WIDTH-1:0]    oReadData,
  output logic [NUM_LSU-1:0]                    oReadDataValid,
  output logic [NUM_LSU-1:0]                    oWriteAccept,
  output logic                                  oReadRequest,
  output logic                                  oWriteRequest,
  output logic [INTERFACE_ADDR_WIDTH-1:0]       oReadAddress,
  output logic [INTERFACE_ADDR_WIDTH-1:0]       oWriteAddress,
  output logic [INTERFACE_WIDTH-1:0]            oWriteData,
  output logic [INTERFACE_WIDTH/8-1:0]          oWriteEnable,
  input  logic [INTERFACE_WIDTH-1:0]            iReadData,
  input  logic                                  iReadDataValid
);

  localparam int ByteWidth = INTERFACE_WIDTH / 8;
  localparam int IdWidth   = (NUM_LSU == NUM_LSU_DEFAULT) ? LSU_ID_WIDTH : $clog2(NUM_LSU);
  localparam int CntWidth  = $clog2(READ_FIFO_DEPTH) + 1;
  localparam logic [NUM_LSU-1:0] OneLane = {{(NUM_LSU-1){1'b0}}, 1'b1};

  logic [INTERFACE_ADDR_WIDTH-1:0] readAddrLane  [NUM_LSU];
  logic [INTERFACE_ADDR_WIDTH-1:0] writeAddrLane [NUM_LSU];
  logic [INTERFACE_WIDTH-1:0]      writeDataLane [NUM_LSU];
  logic [ByteWidth-1:0]            writeEnLane   [NUM_LSU];

  logic [NUM_LSU-1:0]              candidate;
  logic                            readBlocked;
  logic                            anyWinner;
  logic [IdWidth-1:0]              winner;
  logic [IdWidth-1:0]              scanId;
  int                              scanIdx;
  reqKind_t                        winKind;

  reqKind_t                        issueKind;
  logic [IdWidth-1:0]              issueId;
  logic [INTERFACE_ADDR_WIDTH-1:0] issueAddr;
  logic [INTERFACE_WIDTH-1:0]      issueData;
  logic [ByteWidth-1:0]            issueBe;

  logic [CntWidth-1:0]             outstanding;
  logic                            fifoPush;
  logic                            fifoPop;
  logic                            fifoFull;
  logic                            fifoEmpty;
  logic [IdWidth-1:0]              fifoHead;

  genvar g;
  generate
    for (g = 0; g < NUM_LSU; g++) begin : gLane
      assign readAddrLane[g]  = iReadAddress[g*INTERFACE_ADDR_WIDTH +: INTERFACE_ADDR_WIDTH];
      assign writeAddrLane[g] = iWriteAddress[g*INTERFACE_ADDR_WIDTH +: INTERFACE_ADDR_WIDTH];
      assign writeDataLane[g] = iWriteData[g*INTERFACE_WIDTH +: INTERFACE_WIDTH];
      assign writeEnLane[g]   = iWriteEnable[g*ByteWidth +: ByteWidth];
    end
  endgenerate

  // Reads count against the FIFO from grant time, so in-flight issues
  // cannot overrun it; the flag is registered and only clears next cycle.
  assign readBlocked = fifoFull || (outstanding == CntWidth'(READ_FIFO_DEPTH));
  assign candidate   = iWriteRequest | (readBlocked ? '0 : iReadRequest);

`ifndef PERIPH_ARB_FIXED_PRIORITY_EN
  logic [IdWidth-1:0] rrPtr;

  // Pointer moves past the winner; it holds when nobody wins.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rrPtr <= '0;
    end else if (anyWinner) begin
      rrPtr <= IdWidth'(rrNext(int'(winner), NUM_LSU));
    end
  end
`endif

  // Find the first candidate from the scan origin; reads beat writes per port.
  always_comb begin
    anyWinner = 1'b0;
    winner    = '0;
    winKind   = REQ_NONE;
    scanIdx   = 0;
    scanId    = '0;
    for (int k = 0; k < NUM_LSU; k++) begin
`ifdef PERIPH_ARB_FIXED_PRIORITY_EN
      scanIdx = k;
`else
      scanIdx = int'(rrPtr) + k;
      if (scanIdx >= NUM_LSU) scanIdx = scanIdx - NUM_LSU;
`endif
      scanId = IdWidth'(scanIdx);
      if (!anyWinner && candidate[scanId]) begin
        anyWinner = 1'b1;
        winner    = scanId;
        winKind   = (iReadRequest[scanId] && !readBlocked) ? REQ_READ : REQ_WRITE;
      end
    end
    if (iReset) begin
      anyWinner = 1'b0;
      winKind   = REQ_NONE;
    end
  end

  assign oReadGrantNextCycle  = (winKind == REQ_READ)  ? (OneLane << winner) : '0;
  assign oWriteGrantNextCycle = (winKind == REQ_WRITE) ? (OneLane << winner) : '0;

  // Capture the winner's fields so the peripheral sees a registered access.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      issueKind <= REQ_NONE;
      issueId   <= '0;
      issueAddr <= '0;
      issueData <= '0;
      issueBe   <= '0;
    end else begin
      issueKind <= winKind;
      issueId   <= winner;
      if (winKind == REQ_READ) begin
        issueAddr <= readAddrLane[winner];
        issueData <= '0;
        issueBe   <= '0;
      end else if (winKind == REQ_WRITE) begin
        issueAddr <= writeAddrLane[winner];
        issueData <= writeDataLane[winner];
        issueBe   <= writeEnLane[winner];
      end else begin
        issueAddr <= '0;
        issueData <= '0;
        issueBe   <= '0;
      end
    end
  end

  // Reads granted but not yet returned, including the one still in issue.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      outstanding <= '0;
    end else begin
      unique case ({winKind == REQ_READ, fifoPop})
        2'b10:   outstanding <= outstanding + CntWidth'(1);
        2'b01:   outstanding <= outstanding - CntWidth'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign fifoPush = (issueKind == REQ_READ) && !iReset;
  assign fifoPop  = iReadDataValid && !fifoEmpty && !iReset;

  periph_arb_id_fifo #(
    .DEPTH (READ_FIFO_DEPTH),
    .WIDTH (IdWidth)
  ) idFifo (
    .clock    (iClk),
    .reset    (iReset),
    .push     (fifoPush),
    .pushData (issueId),
    .pop      (fifoPop),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign oReadRequest   = (issueKind == REQ_READ)  && !iReset;
  assign oWriteRequest  = (issueKind == REQ_WRITE) && !iReset;
  assign oReadAddress   = oReadRequest  ? issueAddr : '0;
  assign oWriteAddress  = oWriteRequest ? issueAddr : '0;
  assign oWriteData     = oWriteRequest ? issueData : '0;
  assign oWriteEnable   = oWriteRequest ? issueBe   : '0;
  assign oWriteAccept   = oWriteRequest ? (OneLane << issueId) : '0;
  assign oReadDataValid = fifoPop ? (OneLane << fifoHead) : '0;
  assign oReadData      = iReset ? '0 : {NUM_LSU{iReadData}};

endmodule

// File: tb/tb_periph_port_arbiter.sv
// Self-checking bench for periph_port_arbiter: a queue-based model checked
// every cycle on the falling edge, plus directed literal expectations.
module tb_periph_port_arbiter;

  localparam int W     = 32;
  localparam int AW    = 32;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic            iClk = 1'b0;
  logic            iReset;
  logic [N-1:0]    iReadRequest, iWriteRequest;
  logic [N*AW-1:0] iReadAddress, iWriteAddress;
  logic [N*W-1:0]  iWriteData;
  logic [N*4-1:0]  iWriteEnable;
  logic [N-1:0]    oReadGrantNextCycle, oWriteGrantNextCycle;
  logic [N*W-1:0]  oReadData;
  logic [N-1:0]    oReadDataValid, oWriteAccept;
  logic            oReadRequest, oWriteRequest;
  logic [AW-1:0]   oReadAddress, oWriteAddress;
  logic [W-1:0]    oWriteData;
  logic [3:0]      oWriteEnable;
  logic [W-1:0]    iReadData;
  logic            iReadDataValid;

  int checks = 0;
  int errors = 0;

  periph_port_arbiter #(
    .INTERFACE_WIDTH(W), .INTERFACE_ADDR_WIDTH(AW), .NUM_LSU(N), .READ_FIFO_DEPTH(DEPTH)
  ) dut (
    .iClk(iClk), .iReset(iReset),
    .iReadRequest(iReadRequest), .iWriteRequest(iWriteRequest),
    .iReadAddress(iReadAddress), .iWriteAddress(iWriteAddress),
    .iWriteData(iWriteData), .iWriteEnable(iWriteEnable),
    .oReadGrantNextCycle(oReadGrantNextCycle), .oWriteGrantNextCycle(oWriteGrantNextCycle),
    .oReadData(oReadData), .oReadDataValid(oReadDataValid), .oWriteAccept(oWriteAccept),
    .oReadRequest(oReadRequest), .oWriteRequest(oWriteRequest),
    .oReadAddress(oReadAddress), .oWriteAddress(oWriteAddress),
    .oWriteData(oWriteData), .oWriteEnable(oWriteEnable),
    .iReadData(iReadData), .iReadDataValid(iReadDataValid)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr,
                               input logic valid, input logic [W-1:0] data);
    iReadRequest   = rd;
    iWriteRequest  = wr;
    iReadDataValid = valid;
    iReadData      = data;
    #1;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Behavioural model state: pointer, pending issue, queue of read owners.
  int          mPtr = 0;
  int          mKind = 0;
  int          mId = 0;
  logic [31:0] mAddr = '0, mData = '0;
  logic [3:0]  mBe = '0;
  int          mIds[$];

  initial begin
    forever begin
      @(negedge iClk);
      if (iReset) begin
        checkOutput("rstRdGrant", oReadGrantNextCycle, 0);
        checkOutput("rstWrGrant", oWriteGrantNextCycle, 0);
        checkOutput("rstRdStrobe", oReadRequest, 0);
        checkOutput("rstWrStrobe", oWriteRequest, 0);
        checkOutput("rstAccept", oWriteAccept, 0);
        checkOutput("rstValid", oReadDataValid, 0);
        checkOutput("rstRdData", oReadData, 0);
        mPtr = 0; mKind = 0; mId = 0;
        mIds.delete();
      end else begin
        bit full;
        int win;
        bit winRd;
        bit popNow;
        logic [N-1:0] eRdG, eWrG, eValid, eAcc;
        full  = (mIds.size() >= DEPTH);
        win   = -1;
        winRd = 1'b0;
        for (int k = 0; k < N; k++) begin
          int idx;
`ifdef PERIPH_ARB_FIXED_PRIORITY_EN
          idx = k;
`else
          idx = (mPtr + k) % N;
`endif
          if (win < 0 && (iWriteRequest[idx] || (iReadRequest[idx] && !full))) begin
            win   = idx;
            winRd = iReadRequest[idx] && !full;
          end
        end
        eRdG = '0; eWrG = '0;
        if (win >= 0) begin
          if (winRd) eRdG[win] = 1'b1;
          else       eWrG[win] = 1'b1;
        end
        eAcc = '0;
        if (mKind == 2) eAcc[mId] = 1'b1;
        popNow = iReadDataValid && (mIds.size() > 0);
        eValid = '0;
        if (popNow) eValid[mIds[0]] = 1'b1;
        checkOutput("cycRdGrant", oReadGrantNextCycle, eRdG);
        checkOutput("cycWrGrant", oWriteGrantNextCycle, eWrG);
        checkOutput("cycRdStrobe", oReadRequest, mKind == 1);
        checkOutput("cycWrStrobe", oWriteRequest, mKind == 2);
        checkOutput("cycRdAddr", oReadAddress, (mKind == 1) ? mAddr : 32'h0);
        checkOutput("cycWrAddr", oWriteAddress, (mKind == 2) ? mAddr : 32'h0);
        checkOutput("cycWrData", oWriteData, (mKind == 2) ? mData : 32'h0);
        checkOutput("cycWrBe", oWriteEnable, (mKind == 2) ? mBe : 4'h0);
        checkOutput("cycAccept", oWriteAccept, eAcc);
        checkOutput("cycValid", oReadDataValid, eValid);
        if (popNow) checkOutput("cycRdData", oReadData, {N{iReadData}});
        if (popNow) void'(mIds.pop_front());
        if (win >= 0) begin
          mId  = win;
          mPtr = (win + 1) % N;
          if (winRd) begin
            mKind = 1;
            mAddr = iReadAddress[win*AW +: AW];
            mData = '0; mBe = '0;
            mIds.push_back(win);
          end else begin
            mKind = 2;
            mAddr = iWriteAddress[win*AW +: AW];
            mData = iWriteData[win*W +: W];
            mBe   = iWriteEnable[win*4 +: 4];
          end
        end else begin
          mKind = 0;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] exp;
    iReset = 1'b1;
    iReadAddress  = {32'h0000_020C, 32'h0000_0040, 32'h0000_0080, 32'h0000_0200};
    iWriteAddress = {32'h0000_010C, 32'h0000_0108, 32'h0000_0084, 32'h0000_0100};
    iWriteData    = {32'h0000_00A3, 32'h0000_00A2, 32'h1234_5678, 32'h0000_00A0};
    iWriteEnable  = {4'hF, 4'hF, 4'b0011, 4'hF};
    applyStimulus(4'b0000, 4'b1111, 1'b0, 32'h0);

    // Writes held through reset must not be granted or issued.
    step();
    checkOutput("resetGrant", oWriteGrantNextCycle, 4'b0000);
    checkOutput("resetStrobe", oWriteRequest, 1'b0);
    step();
    iReset = 1'b0;
    #1;
    checkOutput("firstGrant", oWriteGrantNextCycle, 4'b0001);
    checkOutput("noIssueFromReset", oWriteRequest, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      step();
`ifdef PERIPH_ARB_FIXED_PRIORITY_EN
      checkOutput("contendGrant", oWriteGrantNextCycle, 4'b0001);
      checkOutput("contendAccept", oWriteAccept, 4'b0001);
`else
      checkOutput("contendGrant", oWriteGrantNextCycle, 4'b0001 << (n % 4));
      checkOutput("contendAccept", oWriteAccept, 4'b0001 << ((n - 1) % 4));
`endif
      if (n == 1) checkOutput("contendAddr", oWriteAddress, 32'h100);
    end
    step();
    applyStimulus(4'b0000, 4'b1001, 1'b0, 32'h0);
    for (int n = 0; n < 3; n++) begin
`ifdef PERIPH_ARB_FIXED_PRIORITY_EN
      exp = 4'b0001;
`else
      exp = (n == 1) ? 4'b0001 : 4'b1000;
`endif
      checkOutput("pairGrant", oWriteGrantNextCycle, exp);
      step();
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    step();

    // Single uncontended read from LSU2.
    applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h0);
    checkOutput("singleGrant", oReadGrantNextCycle, 4'b0100);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("singleStrobe", oReadRequest, 1'b1);
    checkOutput("singleAddr", oReadAddress, 32'h40);
    step();
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'hDEAD);
    checkOutput("singleValid", oReadDataValid, 4'b0100);
    checkOutput("singleData", oReadData[95:64], 32'hDEAD);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

    // LSU1 presents a read and a write together: read first.
    applyStimulus(4'b0010, 4'b0010, 1'b0, 32'h0);
    checkOutput("rbwReadFirst", oReadGrantNextCycle, 4'b0010);
    checkOutput("rbwNoWrite", oWriteGrantNextCycle, 4'b0000);
    step();
    applyStimulus(4'b0000, 4'b0010, 1'b0, 32'h0);
    checkOutput("rbwWriteNext", oWriteGrantNextCycle, 4'b0010);
    checkOutput("rbwRdAddr", oReadAddress, 32'h80);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'hBEEF);
    checkOutput("rbwAccept", oWriteAccept, 4'b0010);
    checkOutput("rbwData", oWriteData, 32'h1234_5678);
    checkOutput("rbwBe", oWriteEnable, 4'b0011);
    checkOutput("rbwWrAddr", oWriteAddress, 32'h84);
    checkOutput("rbwValid", oReadDataValid, 4'b0010);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

    // Fill the read FIFO, then a read is blocked while a write still goes.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0001 << k, 4'b0000, 1'b0, 32'h0);
      checkOutput("fillGrant", oReadGrantNextCycle, 4'b0001 << k);
      step();
    end
    applyStimulus(4'b0001, 4'b1000, 1'b0, 32'h0);
    checkOutput("fullReadBlocked", oReadGrantNextCycle, 4'b0000);
    checkOutput("fullWriteGoes", oWriteGrantNextCycle, 4'b1000);
    step();
    applyStimulus(4'b0001, 4'b0000, 1'b1, 32'h1111);
    checkOutput("fullPopValid", oReadDataValid, 4'b0001);
    checkOutput("popNoUnblock", oReadGrantNextCycle, 4'b0000);
    step();
    applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0);
    checkOutput("readAfterPop", oReadGrantNextCycle, 4'b0001);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h2222);
    checkOutput("orderLsu1", oReadDataValid, 4'b0010);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h3333);
    checkOutput("orderLsu2", oReadDataValid, 4'b0100);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

    // Reset with two reads outstanding; late returns are ignored.
    iReset = 1'b1;
    applyStimulus(4'b0010, 4'b0000, 1'b0, 32'h0);
    checkOutput("midResetGrant", oReadGrantNextCycle, 4'b0000);
    step();
    iReset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h4444);
    checkOutput("lateReturnIgnored", oReadDataValid, 4'b0000);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    step();

    // A fresh read after reset still works end to end.
    applyStimulus(4'b1000, 4'b0000, 1'b0, 32'h0);
    checkOutput("postResetGrant", oReadGrantNextCycle, 4'b1000);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("postResetAddr", oReadAddress, 32'h20C);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h5555);
    checkOutput("postResetValid", oReadDataValid, 4'b1000);
    step();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_port_arbiter.md
# periph_port_arbiter

- Shares one single-ported peripheral or memory port between NUM_LSU load/store units.
- Sits between the per-LSU address-isolation stage and the peripheral.
- Each cycle it selects at most one pending read or write by round-robin, issues it as a registered one-cycle access, and routes in-order read data back to the issuing LSU.
- Issuing LSU IDs are tracked in an internal ID FIFO.

## Interface
- INTERFACE_WIDTH, 32, data width (bits)
- INTERFACE_ADDR_WIDTH, 32, address width (bits)
- NUM_LSU, 4, requester count (≥2)
- READ_FIFO_DEPTH, 4, maximum outstanding reads (power of two, ≥2)
- iClk  in  1  single clock; everything rising-edge
- iReset  in  1  synchronous, active-high reset
- iReadRequest, iWriteRequest  in  NUM_LSU  per-LSU requests
- iReadAddress, iWriteAddress  in  NUM_LSU*INTERFACE_ADDR_WIDTH  packed per LSU
- iWriteData  in  NUM_LSU*INTERFACE_WIDTH  packed per LSU
- iWriteEnable  in  NUM_LSU*(INTERFACE_WIDTH/8)  byte enables, packed per LSU
- oReadGrantNextCycle, oWriteGrantNextCycle  out  NUM_LSU  one-hot-or-zero grants
- oReadData  out  NUM_LSU*INTERFACE_WIDTH  returned data, replicated to every lane
- oReadDataValid  out  NUM_LSU  one-hot-or-zero
- oWriteAccept  out  NUM_LSU  one-hot-or-zero
- oReadRequest, oWriteRequest  out  1  peripheral strobes
- oReadAddress, oWriteAddress  out  INTERFACE_ADDR_WIDTH  peripheral addresses
- oWriteData  out  INTERFACE_WIDTH  peripheral write data
- oWriteEnable  out  INTERFACE_WIDTH/8  peripheral byte enables
- iReadData  in  INTERFACE_WIDTH  peripheral read data
- iReadDataValid  in  1  peripheral read-data strobe; returns strictly in issue order

## Operation
Candidate selection (cycle t):
- Port i is a candidate if iWriteRequest[i] is set, or iReadRequest[i] is set and the ID FIFO is not full.
- A port presenting both a read and a write is served read first. The write remains pending until a later win.

Grant (cycle t):
- The winner is the first candidate at or after the round-robin pointer, scanning upward and wrapping at NUM_LSU-1 → 0.
- The grant is combinational and is exactly one of oReadGrantNextCycle[w] or oWriteGrantNextCycle[w].
- The arbiter captures the winner's address, data, byte enables and ID in issue registers at the end of cycle t.
- The pointer updates to (w+1) mod NUM_LSU. With no winner, the pointer holds.

Issue (cycle t+1):
- Peripheral strobe is high for exactly one cycle with the registered fields.
- For a write, oWriteAccept[w] is high in the same cycle.
- For a read, w is pushed into the ID FIFO.

Read return:
- On iReadDataValid, the FIFO is popped and oReadDataValid[head] is asserted combinationally in the same cycle, with oReadData = iReadData.
- iReadDataValid with an empty FIFO is a protocol error. It is ignored: no valid output and no pop.
- Simultaneous push and pop is allowed; occupancy is unchanged.

Requester rule:
- An LSU holds request, address and data stable until its grant. It may change them in the cycle after its grant.

Reset:
- All outputs are 0 and the pointer is 0.
- The ID FIFO is emptied; outstanding reads are discarded, and their late returns count as empty-FIFO returns.
- A grant seen in the reset cycle is not issued.

## Timing
- Request-to-grant: 0 cycles if uncontended.
- Grant-to-peripheral strobe: 1 cycle.
- Read-data return: combinational pass-through, 0 added latency.
- Throughput: 1 access per cycle.
- Fairness: any held request is granted within NUM_LSU cycles, provided the FIFO does not stay full.
- FIFO full: read grants are suppressed; writes are still granted.
- A pop in the same cycle as full does not unblock a read until the next cycle (full is registered).

## Configuration
- PERIPH_ARB_FIXED_PRIORITY_EN defined: the lowest-index candidate always wins, the pointer logic is removed and the fairness bound is void.
- Undefined (default): round-robin as above.

## Structure
- Shared package periph_arb_pkg holds the LSU-ID width constant (clog2 of NUM_LSU), the request-kind enum (NONE/READ/WRITE) and the round-robin helper function.
- Sub-module periph_arb_id_fifo: synchronous FIFO of LSU IDs with push/pop/full/empty. Its head is read combinationally.

## Test plan
- Single request: LSU2 reads addr 0x40 at t → oReadGrantNextCycle=0b0100 at t, oReadRequest=1 with addr 0x40 at t+1; iReadData=0xDEAD at t+3 → oReadDataValid=0b0100, data 0xDEAD.
- Contention: all 4 LSUs hold writes from reset → grants 0,1,2,3,0… on consecutive cycles, oWriteAccept one-hot following 1 cycle later.
- Read-before-write: LSU1 holds a read and a write → the read is granted first, the write on its next win; data and byte enables (0b0011) match.
- FIFO full: 4 reads issued with no return, then a 5th read plus LSU3 write → only the write is granted; one return → the 5th read is granted the cycle after.
- Reset mid-operation: 2 reads outstanding, assert iReset for 1 cycle → all outputs 0; a subsequent iReadDataValid produces no oReadDataValid.
- With PERIPH_ARB_FIXED_PRIORITY_EN: LSU0 and LSU3 hold writes → LSU0 is granted every cycle and LSU3 never.
